// File: rtl/aos_tlb_xlate.sv
// Pops one virtual request, translates it through a direct-mapped TLB and issues it as a physical AR/AW beat.
// Hit: valid two cycles after pop (min 3 cycles/request); valid/payload held until ready; a miss stalls until a fill hits the index.
`timescale 1ns/1ps
module aos_tlb_xlate #(
   parameter int PAGE_BITS = 21,
   parameter int TLB_LD    = 6,
   parameter int ID_W      = 16,
   parameter int ADDR_W    = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rq_empty,
   input  logic [ID_W+ADDR_W+11:0]       rq_dout,
   output logic                          rq_rdreq,
   output logic                          phys_arvalid,
   input  logic                          phys_arready,
   output logic [ID_W-1:0]               phys_arid,
   output logic [ADDR_W-1:0]             phys_araddr,
   output logic [7:0]                    phys_arlen,
   output logic [2:0]                    phys_arsize,
   output logic                          phys_awvalid,
   input  logic                          phys_awready,
   output logic [ID_W-1:0]               phys_awid,
   output logic [ADDR_W-1:0]             phys_awaddr,
   output logic [7:0]                    phys_awlen,
   output logic [2:0]                    phys_awsize,
   input  logic                          tlb_wr_en,
   input  logic [TLB_LD-1:0]             tlb_wr_idx,
   input  logic [ADDR_W-PAGE_BITS-1:0]   tlb_wr_vpn,
   input  logic [ADDR_W-PAGE_BITS-1:0]   tlb_wr_ppn,
   input  logic                          tlb_wr_vld,
   input  logic                          tlb_flush,
   output logic                          miss_valid,
   output logic [ADDR_W-PAGE_BITS-1:0]   miss_vpn,
   output logic [31:0]                   hit_cnt,
   output logic [31:0]                   miss_cnt
);
   localparam int VPN_W   = ADDR_W - PAGE_BITS;
   localparam int TAG_W   = VPN_W - TLB_LD;
   localparam int ENTRIES = 1 << TLB_LD;
   localparam int RQ_W    = 1 + ID_W + ADDR_W + 11;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_ISSUE, S_MISS} state_t;
   state_t state, state_nxt;

   logic              req_rd;
   logic [ID_W-1:0]   req_id;
   logic [ADDR_W-1:0] req_vaddr;
   logic [7:0]        req_len;
   logic [2:0]        req_size;
   logic [VPN_W-1:0]  req_ppn;

   logic [ENTRIES-1:0] tlb_vld;
   logic [TAG_W-1:0]   tlb_tag [ENTRIES];
   logic [VPN_W-1:0]   tlb_ppn [ENTRIES];

   logic [TLB_LD-1:0] idx;
   logic              tlb_hit, wr_to_idx, do_hit, do_miss;
   logic              unused_vpn_lo;

   assign idx           = req_vaddr[PAGE_BITS +: TLB_LD];
   assign tlb_hit       = tlb_vld[idx] && (tlb_tag[idx] == req_vaddr[ADDR_W-1 -: TAG_W]);
   assign wr_to_idx     = tlb_wr_en && (tlb_wr_idx == idx);
   // The index is supplied explicitly, so the low VPN bits carry no information.
   assign unused_vpn_lo = ^tlb_wr_vpn[TLB_LD-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      rq_rdreq     = 1'b0;
      phys_arvalid = 1'b0;
      phys_awvalid = 1'b0;
      miss_valid   = 1'b0;
      do_hit       = 1'b0;
      do_miss      = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rq_empty) begin
               rq_rdreq  = 1'b1;
               state_nxt = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            // A concurrent update to the looked-up entry is not visible yet; look again next cycle.
            if (tlb_flush || wr_to_idx) begin
               state_nxt = S_LOOKUP;
            end else if (tlb_hit) begin
               do_hit    = 1'b1;
               state_nxt = S_ISSUE;
            end else begin
               do_miss   = 1'b1;
               state_nxt = S_MISS;
            end
         end
         S_ISSUE: begin
            phys_arvalid = req_rd;
            phys_awvalid = !req_rd;
            if ((req_rd && phys_arready) || (!req_rd && phys_awready)) state_nxt = S_IDLE;
         end
         S_MISS: begin
            miss_valid = 1'b1;
            if (wr_to_idx) state_nxt = S_LOOKUP;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_rd    <= 1'b0;
         req_id    <= '0;
         req_vaddr <= '0;
         req_len   <= '0;
         req_size  <= '0;
         req_ppn   <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         if (rq_rdreq) begin
            req_rd    <= rq_dout[RQ_W-1];
            req_id    <= rq_dout[RQ_W-2 -: ID_W];
            req_vaddr <= rq_dout[ADDR_W+10:11];
            req_len   <= rq_dout[10:3];
            req_size  <= rq_dout[2:0];
         end
         // PPN is captured at the hit so later TLB writes/flushes cannot disturb an issuing beat.
         if (do_hit) begin
            req_ppn <= tlb_ppn[idx];
            hit_cnt <= hit_cnt + 32'd1;
         end
         if (do_miss) miss_cnt <= miss_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         tlb_vld <= '0;
      else if (tlb_flush) tlb_vld <= '0;
      else if (tlb_wr_en) tlb_vld[tlb_wr_idx] <= tlb_wr_vld;
   end

   always_ff @(posedge clk) begin
      if (tlb_wr_en) begin
         tlb_tag[tlb_wr_idx] <= tlb_wr_vpn[VPN_W-1:TLB_LD];
         tlb_ppn[tlb_wr_idx] <= tlb_wr_ppn;
      end
   end

   assign phys_arid   = req_id;
   assign phys_araddr = {req_ppn, req_vaddr[PAGE_BITS-1:0]};
   assign phys_arlen  = req_len;
   assign phys_arsize = req_size;
   assign phys_awid   = req_id;
   assign phys_awaddr = {req_ppn, req_vaddr[PAGE_BITS-1:0]};
   assign phys_awlen  = req_len;
   assign phys_awsize = req_size;
   assign miss_vpn    = miss_valid ? req_vaddr[ADDR_W-1:PAGE_BITS] : '0;
endmodule

// File: tb/tb_aos_tlb_xlate.sv
// Randomized and directed bench for aos_tlb_xlate with a request-level reference model.
`timescale 1ns/1ps
module tb_aos_tlb_xlate;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rq_empty;
   logic [91:0] rq_dout;
   logic        rq_rdreq;
   logic        phys_arvalid, phys_arready;
   logic [15:0] phys_arid;
   logic [63:0] phys_araddr;
   logic [7:0]  phys_arlen;
   logic [2:0]  phys_arsize;
   logic        phys_awvalid, phys_awready;
   logic [15:0] phys_awid;
   logic [63:0] phys_awaddr;
   logic [7:0]  phys_awlen;
   logic [2:0]  phys_awsize;
   logic        tlb_wr_en;
   logic [5:0]  tlb_wr_idx;
   logic [42:0] tlb_wr_vpn, tlb_wr_ppn;
   logic        tlb_wr_vld, tlb_flush;
   logic        miss_valid;
   logic [42:0] miss_vpn;
   logic [31:0] hit_cnt, miss_cnt;

   always #5 clk = ~clk;

   aos_tlb_xlate dut (
      .clk(clk), .rst_n(rst_n), .rq_empty(rq_empty), .rq_dout(rq_dout), .rq_rdreq(rq_rdreq),
      .phys_arvalid(phys_arvalid), .phys_arready(phys_arready), .phys_arid(phys_arid),
      .phys_araddr(phys_araddr), .phys_arlen(phys_arlen), .phys_arsize(phys_arsize),
      .phys_awvalid(phys_awvalid), .phys_awready(phys_awready), .phys_awid(phys_awid),
      .phys_awaddr(phys_awaddr), .phys_awlen(phys_awlen), .phys_awsize(phys_awsize),
      .tlb_wr_en(tlb_wr_en), .tlb_wr_idx(tlb_wr_idx), .tlb_wr_vpn(tlb_wr_vpn),
      .tlb_wr_ppn(tlb_wr_ppn), .tlb_wr_vld(tlb_wr_vld), .tlb_flush(tlb_flush),
      .miss_valid(miss_valid), .miss_vpn(miss_vpn), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   typedef struct {
      bit        rd;
      bit [15:0] id;
      bit [63:0] va;
      bit [7:0]  len;
      bit [2:0]  size;
   } req_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Show-ahead request FIFO owned by the bench.
   req_t fifo_q[$];
   bit   pop_now = 1'b0;

   function automatic void refresh();
      rq_empty = (fifo_q.size() == 0);
      rq_dout  = rq_empty ? 92'd0 : {fifo_q[0].rd, fifo_q[0].id, fifo_q[0].va, fifo_q[0].len, fifo_q[0].size};
   endfunction

   task automatic push(input req_t r);
      fifo_q.push_back(r);
      refresh();
   endtask

   initial forever begin
      @(posedge clk);
      if (pop_now) begin
         pop_now = 1'b0;
         #1;
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         refresh();
      end
   end

   // Reference model: one held request whose lookup result is pending, hit or miss.
   bit        m_have;
   int        m_look;
   req_t      m_req;
   bit [42:0] m_ppn;
   bit [31:0] m_hits, m_misses;
   bit        m_vld  [64];
   bit [36:0] m_tag  [64];
   bit [42:0] m_tppn [64];
   bit        e_rd, e_ar, e_aw, e_miss;
   bit [42:0] m_vpn;
   int        m_idx;
   bit [15:0] dut_issued[$];

   initial forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
         m_have = 0; m_look = 0; m_hits = 0; m_misses = 0; pop_now = 1'b0;
         for (int i = 0; i < 64; i++) m_vld[i] = 0;
         chk("rst_arvalid", phys_arvalid, 0);
         chk("rst_miss_valid", miss_valid, 0);
      end else begin
         e_rd   = !m_have && (fifo_q.size() > 0);
         e_ar   = m_have && m_look == 1 && m_req.rd;
         e_aw   = m_have && m_look == 1 && !m_req.rd;
         e_miss = m_have && m_look == 2;
         chk("rq_rdreq", rq_rdreq, e_rd);
         chk("arvalid", phys_arvalid, e_ar);
         chk("awvalid", phys_awvalid, e_aw);
         chk("miss_valid", miss_valid, e_miss);
         chk("hit_cnt", hit_cnt, m_hits);
         chk("miss_cnt", miss_cnt, m_misses);
         if (e_ar) begin
            chk("araddr", phys_araddr, {m_ppn, m_req.va[20:0]});
            chk("arid", phys_arid, m_req.id);
            chk("arlen", phys_arlen, m_req.len);
            chk("arsize", phys_arsize, m_req.size);
         end
         if (e_aw) begin
            chk("awaddr", phys_awaddr, {m_ppn, m_req.va[20:0]});
            chk("awid", phys_awid, m_req.id);
            chk("awlen", phys_awlen, m_req.len);
            chk("awsize", phys_awsize, m_req.size);
         end
         if (e_miss) chk("miss_vpn", miss_vpn, m_req.va[63:21]);
         if (phys_arvalid && phys_arready) dut_issued.push_back(phys_arid);
         if (phys_awvalid && phys_awready) dut_issued.push_back(phys_awid);

         m_vpn = m_req.va[63:21];
         m_idx = int'(m_vpn[5:0]);
         if (m_have) begin
            if (m_look == 0) begin
               if (!(tlb_flush || (tlb_wr_en && int'(tlb_wr_idx) == m_idx))) begin
                  if (m_vld[m_idx] && m_tag[m_idx] == m_vpn[42:6]) begin
                     m_look = 1; m_ppn = m_tppn[m_idx]; m_hits++;
                  end else begin
                     m_look = 2; m_misses++;
                  end
               end
            end else if (m_look == 1) begin
               if (m_req.rd ? phys_arready : phys_awready) m_have = 0;
            end else begin
               if (tlb_wr_en && int'(tlb_wr_idx) == m_idx) m_look = 0;
            end
         end else if (e_rd) begin
            m_have = 1; m_req = fifo_q[0]; m_look = 0;
         end
         if (rq_rdreq) pop_now = 1'b1;
         if (tlb_flush) begin
            for (int i = 0; i < 64; i++) m_vld[i] = 0;
         end else if (tlb_wr_en) begin
            m_vld[tlb_wr_idx]  = tlb_wr_vld;
            m_tag[tlb_wr_idx]  = tlb_wr_vpn[42:6];
            m_tppn[tlb_wr_idx] = tlb_wr_ppn;
         end
      end
   end

   // Called at a falling edge; returns at the next falling edge with the write deasserted.
   task automatic tlb_write(input int idx, input bit [42:0] vpn, input bit [42:0] ppn, input bit vld);
      tlb_wr_en = 1; tlb_wr_idx = 6'(idx); tlb_wr_vpn = vpn; tlb_wr_ppn = ppn; tlb_wr_vld = vld;
      @(negedge clk);
      tlb_wr_en = 0;
   endtask

   task automatic wait_until(input string name, input int sel);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk); #3;
         case (sel)
            0:       seen = phys_arvalid;
            1:       seen = phys_awvalid;
            default: seen = miss_valid;
         endcase
      end
      chk(name, seen, 1);
   endtask

   req_t      r;
   bit [15:0] exp_order[$];
   bit [63:0] hold_addr;
   int        pushed;

   initial begin
      phys_arready = 0; phys_awready = 0; tlb_wr_en = 0; tlb_wr_idx = 0;
      tlb_wr_vpn = 0; tlb_wr_ppn = 0; tlb_wr_vld = 0; tlb_flush = 0;
      refresh();
      repeat (3) @(negedge clk);
      #3;
      chk("reset_rdreq", rq_rdreq, 0);
      chk("reset_awvalid", phys_awvalid, 0);
      chk("reset_hit_cnt", hit_cnt, 0);
      chk("reset_miss_cnt", miss_cnt, 0);
      @(negedge clk); rst_n = 1;

      // Hit on idx 3 with a stalled AR channel.
      @(negedge clk);
      tlb_write(3, 43'h3, 43'h80, 1);
      r = '{rd: 1, id: 16'h5, va: 64'h0060_1234, len: 8'd7, size: 3'd3};
      push(r);
      #3 chk("t1_pop", rq_rdreq, 1);
      @(negedge clk); #3 chk("t1_no_early_ar", phys_arvalid, 0);
      @(negedge clk); #3;
      chk("t1_arvalid", phys_arvalid, 1);
      chk("t1_araddr", phys_araddr, 64'h1000_1234);
      chk("t1_arid", phys_arid, 16'h5);
      chk("t1_arlen", phys_arlen, 8'd7);
      chk("t1_hit_cnt", hit_cnt, 32'd1);
      hold_addr = phys_araddr;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            r = '{rd: 0, id: 16'h77, va: 64'h0120_0ABC, len: 8'd3, size: 3'd2};
            push(r);
         end
         #3;
         chk("hold_arvalid", phys_arvalid, 1);
         chk("hold_araddr", phys_araddr, hold_addr);
         chk("hold_no_pop", rq_rdreq, 0);
      end
      @(negedge clk); phys_arready = 1;
      @(negedge clk); phys_arready = 0;

      // Miss on vpn 9, then fill.
      wait_until("t2_miss_seen", 2);
      chk("t2_miss_vpn", miss_vpn, 43'h9);
      chk("t2_no_aw", phys_awvalid, 0);
      chk("t2_miss_cnt", miss_cnt, 32'd1);
      @(negedge clk);
      tlb_write(9, 43'h9, 43'h1234, 1);
      wait_until("t2_aw_seen", 1);
      chk("t2_awaddr", phys_awaddr, 64'h0000_0002_4680_0ABC);
      chk("t2_awid", phys_awid, 16'h77);
      chk("t2_miss_cnt_after", miss_cnt, 32'd1);
      chk("t2_hit_cnt_after", hit_cnt, 32'd2);
      @(negedge clk); phys_awready = 1;
      @(negedge clk); phys_awready = 0;

      // Random alternating traffic with random ready, fills, invalidates and flushes.
      for (int k = 0; k < 8; k++) tlb_write(k, 43'(k), 43'($urandom), 1);
      dut_issued.delete();
      exp_order.delete();
      pushed = 0;
      for (int cyc = 0; cyc < 4000 && dut_issued.size() < 40; cyc++) begin
         @(negedge clk);
         phys_arready = 1'($urandom % 2);
         phys_awready = 1'($urandom % 2);
         tlb_wr_en = 0; tlb_flush = 0;
         if (pushed < 40 && fifo_q.size() < 2 && ($urandom % 2) == 1) begin
            r.rd = (pushed % 2) == 0;
            r.id = 16'h100 + 16'(pushed);
            r.va = {43'($urandom_range(0, 11)), 21'($urandom)};
            r.len = 8'($urandom);
            r.size = 3'($urandom);
            push(r);
            exp_order.push_back(r.id);
            pushed++;
         end
         if (miss_valid && ($urandom % 3) == 0) begin
            tlb_wr_en = 1; tlb_wr_idx = miss_vpn[5:0]; tlb_wr_vpn = miss_vpn;
            tlb_wr_ppn = 43'($urandom); tlb_wr_vld = 1;
         end else if (($urandom % 16) == 0) begin
            tlb_wr_en = 1; tlb_wr_idx = 6'($urandom_range(0, 11)); tlb_wr_vpn = 43'(tlb_wr_idx);
            tlb_wr_ppn = 43'($urandom); tlb_wr_vld = ($urandom % 4) != 0;
         end else if (($urandom % 64) == 0) begin
            tlb_flush = 1;
         end
      end
      @(negedge clk);
      tlb_wr_en = 0; tlb_flush = 0; phys_arready = 0; phys_awready = 0;
      chk("rand_issue_count", dut_issued.size(), 40);
      for (int i = 0; i < 40 && i < dut_issued.size(); i++) chk("rand_issue_order", dut_issued[i], exp_order[i]);

      // Flush wins over a same-cycle write; then reset while stalled.
      repeat (3) @(negedge clk);
      tlb_flush = 1; tlb_wr_en = 1; tlb_wr_idx = 6'd3; tlb_wr_vpn = 43'h3; tlb_wr_ppn = 43'h80; tlb_wr_vld = 1;
      @(negedge clk);
      tlb_flush = 0; tlb_wr_en = 0;
      r = '{rd: 1, id: 16'h55, va: 64'h0060_0040, len: 8'd1, size: 3'd2};
      push(r);
      wait_until("t4_flush_miss", 2);
      chk("t4_miss_vpn", miss_vpn, 43'h3);
      @(negedge clk);
      fifo_q.delete();
      refresh();
      rst_n = 0;
      #1;
      chk("t4_rst_miss_valid", miss_valid, 0);
      chk("t4_rst_miss_vpn", miss_vpn, 0);
      chk("t4_rst_hit_cnt", hit_cnt, 0);
      chk("t4_rst_miss_cnt", miss_cnt, 0);
      @(negedge clk); rst_n = 1;
      repeat (4) @(negedge clk);
      #3;
      chk("t4_post_arvalid", phys_arvalid, 0);
      chk("t4_post_hit_cnt", hit_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
